// File: rtl/pcie_axis_chan_mux.sv
// Shares one XDMA H2C/C2H AXI-Stream pair among NUM_CH application channels:
// H2C packets are steered by a header channel ID, C2H packets are merged round-robin.
module pcie_axis_chan_mux #(
  parameter int DATA_WIDTH  = 256,
  parameter int NUM_CH      = 4,
  parameter int CH_ID_LSB   = 0,
  parameter int CH_ID_WIDTH = 8
) (
  input  logic                           axis_clk,
  input  logic                           axis_rst_n,
  input  logic                           link_up,
  input  logic [DATA_WIDTH-1:0]          s_h2c_tdata,
  input  logic [DATA_WIDTH/8-1:0]        s_h2c_tkeep,
  input  logic                           s_h2c_tlast,
  input  logic                           s_h2c_tvalid,
  output logic                           s_h2c_tready,
  output logic [NUM_CH*DATA_WIDTH-1:0]   m_ch_tdata,
  output logic [NUM_CH*DATA_WIDTH/8-1:0] m_ch_tkeep,
  output logic [NUM_CH-1:0]              m_ch_tlast,
  output logic [NUM_CH-1:0]              m_ch_tvalid,
  input  logic [NUM_CH-1:0]              m_ch_tready,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   s_ch_tdata,
  input  logic [NUM_CH*DATA_WIDTH/8-1:0] s_ch_tkeep,
  input  logic [NUM_CH-1:0]              s_ch_tlast,
  input  logic [NUM_CH-1:0]              s_ch_tvalid,
  output logic [NUM_CH-1:0]              s_ch_tready,
  output logic [DATA_WIDTH-1:0]          m_c2h_tdata,
  output logic [DATA_WIDTH/8-1:0]        m_c2h_tkeep,
  output logic                           m_c2h_tlast,
  output logic                           m_c2h_tvalid,
  input  logic                           m_c2h_tready,
  output logic [31:0]                    h2c_drop_cnt,
  output logic [NUM_CH-1:0]              c2h_grant
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int SEL_W  = $clog2(NUM_CH);

  typedef enum logic [1:0] {IDLE, FWD, DROP} h2c_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  h2c_state_t              state, state_nxt;
  logic [SEL_W-1:0]        sel, sel_nxt;
  logic [CH_ID_WIDTH-1:0]  hdr_id;
  logic [SEL_W-1:0]        hdr_sel;
  logic                    hdr_ok;
  logic [NUM_CH-1:0]       h2c_vld;
  logic                    h2c_rdy;
  logic                    drop_hs;

  // H2C: combinational steering; only the header beat in IDLE carries the ID.
  assign hdr_id  = s_h2c_tdata[CH_ID_LSB +: CH_ID_WIDTH];
  assign hdr_sel = hdr_id[SEL_W-1:0];
  assign hdr_ok  = (32'(hdr_id) < 32'(NUM_CH));

  assign m_ch_tdata = {NUM_CH{s_h2c_tdata}};
  assign m_ch_tkeep = {NUM_CH{s_h2c_tkeep}};
  assign m_ch_tlast = {NUM_CH{s_h2c_tlast}};

  // Handshakes are held off while reset is asserted, even though the path is combinational.
  assign m_ch_tvalid  = h2c_vld & {NUM_CH{axis_rst_n}};
  assign s_h2c_tready = h2c_rdy & axis_rst_n;

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    h2c_vld   = '0;
    h2c_rdy   = 1'b0;
    drop_hs   = 1'b0;
    case (state)
      IDLE: begin
        if (hdr_ok) begin
          h2c_vld[hdr_sel] = s_h2c_tvalid;
          h2c_rdy          = m_ch_tready[hdr_sel];
          if (s_h2c_tvalid && h2c_rdy && !s_h2c_tlast) begin
            state_nxt = FWD;
            sel_nxt   = hdr_sel;
          end
        end else begin
          h2c_rdy = 1'b1;
          if (s_h2c_tvalid) begin
            drop_hs = 1'b1;
            if (!s_h2c_tlast) state_nxt = DROP;
          end
        end
      end
      FWD: begin
        h2c_vld[sel] = s_h2c_tvalid;
        h2c_rdy      = m_ch_tready[sel];
        if (s_h2c_tvalid && h2c_rdy && s_h2c_tlast) state_nxt = IDLE;
      end
      DROP: begin
        h2c_rdy = 1'b1;
        if (s_h2c_tvalid && s_h2c_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state        <= IDLE;
      sel          <= '0;
      h2c_drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      if (drop_hs) h2c_drop_cnt <= sat_inc(h2c_drop_cnt);
    end
  end

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W-1:0] cand;
  logic [SEL_W-1:0] pick;
  logic             found;
  logic             grant_active;

  // C2H: round-robin search starting just after the last owner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = SEL_W'((int'(ptr) + k) % NUM_CH);
      if (!found && s_ch_tvalid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign grant_active = |c2h_grant;
  assign m_c2h_tdata  = s_ch_tdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
  assign m_c2h_tkeep  = s_ch_tkeep[gnt_idx*KEEP_W +: KEEP_W];
  assign m_c2h_tlast  = s_ch_tlast[gnt_idx];
  assign m_c2h_tvalid = grant_active & s_ch_tvalid[gnt_idx];
  assign s_ch_tready  = c2h_grant & {NUM_CH{m_c2h_tready}};

  // Grant is held until the owner's tlast handshake; link_up only gates new grants.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      c2h_grant <= '0;
      gnt_idx   <= '0;
      ptr       <= SEL_W'(NUM_CH - 1);
    end else if (grant_active) begin
      if (m_c2h_tvalid && m_c2h_tready && m_c2h_tlast) c2h_grant <= '0;
    end else if (link_up && found) begin
      c2h_grant <= {{(NUM_CH-1){1'b0}}, 1'b1} << pick;
      gnt_idx   <= pick;
      ptr       <= pick;
    end
  end

endmodule

// File: tb/tb_pcie_axis_chan_mux.sv
// Directed bench for pcie_axis_chan_mux with 4 channels and 32-bit data.
module tb_pcie_axis_chan_mux;
  localparam int DW  = 32;
  localparam int NCH = 4;

  logic              axis_clk = 1'b0;
  logic              axis_rst_n;
  logic              link_up;
  logic [DW-1:0]     s_h2c_tdata;
  logic [DW/8-1:0]   s_h2c_tkeep;
  logic              s_h2c_tlast, s_h2c_tvalid, s_h2c_tready;
  logic [NCH*DW-1:0] m_ch_tdata;
  logic [NCH*DW/8-1:0] m_ch_tkeep;
  logic [NCH-1:0]    m_ch_tlast, m_ch_tvalid, m_ch_tready;
  logic [NCH*DW-1:0] s_ch_tdata;
  logic [NCH*DW/8-1:0] s_ch_tkeep;
  logic [NCH-1:0]    s_ch_tlast, s_ch_tvalid, s_ch_tready;
  logic [DW-1:0]     m_c2h_tdata;
  logic [DW/8-1:0]   m_c2h_tkeep;
  logic              m_c2h_tlast, m_c2h_tvalid, m_c2h_tready;
  logic [31:0]       h2c_drop_cnt;
  logic [NCH-1:0]    c2h_grant;

  int checks = 0;
  int failures = 0;
  int src_pkts[NCH];
  int src_len[NCH];
  int src_beat[NCH];
  int src_tot[NCH];

  pcie_axis_chan_mux #(.DATA_WIDTH(DW), .NUM_CH(NCH), .CH_ID_LSB(0), .CH_ID_WIDTH(8)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .link_up(link_up),
    .s_h2c_tdata(s_h2c_tdata), .s_h2c_tkeep(s_h2c_tkeep), .s_h2c_tlast(s_h2c_tlast),
    .s_h2c_tvalid(s_h2c_tvalid), .s_h2c_tready(s_h2c_tready),
    .m_ch_tdata(m_ch_tdata), .m_ch_tkeep(m_ch_tkeep), .m_ch_tlast(m_ch_tlast),
    .m_ch_tvalid(m_ch_tvalid), .m_ch_tready(m_ch_tready),
    .s_ch_tdata(s_ch_tdata), .s_ch_tkeep(s_ch_tkeep), .s_ch_tlast(s_ch_tlast),
    .s_ch_tvalid(s_ch_tvalid), .s_ch_tready(s_ch_tready),
    .m_c2h_tdata(m_c2h_tdata), .m_c2h_tkeep(m_c2h_tkeep), .m_c2h_tlast(m_c2h_tlast),
    .m_c2h_tvalid(m_c2h_tvalid), .m_c2h_tready(m_c2h_tready),
    .h2c_drop_cnt(h2c_drop_cnt), .c2h_grant(c2h_grant)
  );

  always #5 axis_clk = ~axis_clk;

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic h2c_beat(input logic [31:0] data, input logic last);
    s_h2c_tdata  = data;
    s_h2c_tkeep  = 4'hF;
    s_h2c_tlast  = last;
    s_h2c_tvalid = 1'b1;
  endtask

  // Source beat payload is 0xC000 | ch<<4 | running beat count of that channel.
  task automatic drive_sources();
    for (int c = 0; c < NCH; c++) begin
      s_ch_tvalid[c]          = (src_pkts[c] > 0);
      s_ch_tdata[c*DW +: DW]  = 32'h0000_C000 | (32'(c) << 4) | 32'(src_tot[c]);
      s_ch_tkeep[c*4 +: 4]    = 4'hF;
      s_ch_tlast[c]           = (src_beat[c] == src_len[c] - 1);
    end
  endtask

  task automatic advance_sources(input logic [NCH-1:0] hs);
    for (int c = 0; c < NCH; c++) begin
      if (hs[c]) begin
        src_tot[c]++;
        if (src_beat[c] == src_len[c] - 1) begin
          src_beat[c] = 0;
          src_pkts[c]--;
        end else begin
          src_beat[c]++;
        end
      end
    end
  endtask

  task automatic test_reset();
    axis_rst_n = 1'b0;
    link_up = 1'b1;
    h2c_beat(32'h0000_0007, 1'b1);
    m_ch_tready = 4'hF;
    m_c2h_tready = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      src_pkts[c] = 0; src_len[c] = 1; src_beat[c] = 0; src_tot[c] = 0;
    end
    drive_sources();
    #2;
    checks++; if (s_h2c_tready !== 1'b0) begin failures++; $display("FAIL rst_h2c_tready got=%b exp=0", s_h2c_tready); end
    checks++; if (m_ch_tvalid !== 4'h0) begin failures++; $display("FAIL rst_m_ch_tvalid got=%h exp=0", m_ch_tvalid); end
    checks++; if (c2h_grant !== 4'h0) begin failures++; $display("FAIL rst_grant got=%h exp=0", c2h_grant); end
    checks++; if (h2c_drop_cnt !== 32'd0) begin failures++; $display("FAIL rst_drop_cnt got=%0d exp=0", h2c_drop_cnt); end
    checks++; if (m_c2h_tvalid !== 1'b0 || s_ch_tready !== 4'h0) begin
      failures++; $display("FAIL rst_c2h got vld=%b rdy=%h exp 0/0", m_c2h_tvalid, s_ch_tready);
    end
    s_h2c_tvalid = 1'b0;
    tick(); tick();
    axis_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_h2c_fwd();
    logic [31:0] dat [3];
    dat = '{32'hA5A5_0002, 32'h1111_1107, 32'h2222_2203};
    m_ch_tready = 4'hF;
    for (int i = 0; i < 3; i++) begin
      h2c_beat(dat[i], i == 2);
      if (i == 2) s_h2c_tkeep = 4'h7;
      #1;
      checks++; if (m_ch_tvalid !== 4'b0100 || s_h2c_tready !== 1'b1) begin
        failures++; $display("FAIL fwd_vld beat%0d got vld=%h rdy=%b exp vld=4 rdy=1", i, m_ch_tvalid, s_h2c_tready);
      end
      checks++; if (m_ch_tdata[2*DW +: DW] !== dat[i] || m_ch_tlast[2] !== (i == 2)) begin
        failures++; $display("FAIL fwd_data beat%0d got %h/%b exp %h/%b", i, m_ch_tdata[2*DW +: DW], m_ch_tlast[2], dat[i], i == 2);
      end
      tick();
    end
    checks++; if (m_ch_tkeep[8 +: 4] !== 4'h7) begin failures++; $display("FAIL fwd_keep got=%h exp=7", m_ch_tkeep[8 +: 4]); end
    s_h2c_tvalid = 1'b0;
    #1;
    checks++; if (h2c_drop_cnt !== 32'd0) begin failures++; $display("FAIL fwd_drop_cnt got=%0d exp=0", h2c_drop_cnt); end
  endtask

  task automatic test_h2c_drop();
    logic [31:0] dat [5];
    logic        lst [5];
    logic [3:0]  evld [5];
    dat  = '{32'h0000_0007, 32'hBEEF_0001, 32'hCAFE_0009, 32'h0000_0020, 32'h0000_0000};
    lst  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    evld = '{4'h0, 4'b0010, 4'b0010, 4'h0, 4'h0};
    m_ch_tready = 4'hF;
    for (int i = 0; i < 5; i++) begin
      h2c_beat(dat[i], lst[i]);
      #1;
      checks++; if (m_ch_tvalid !== evld[i] || s_h2c_tready !== 1'b1) begin
        failures++; $display("FAIL drop_route beat%0d got vld=%h rdy=%b exp vld=%h rdy=1", i, m_ch_tvalid, s_h2c_tready, evld[i]);
      end
      tick();
      if (i == 0) begin
        checks++; if (h2c_drop_cnt !== 32'd1) begin failures++; $display("FAIL drop_cnt_single got=%0d exp=1", h2c_drop_cnt); end
      end
    end
    s_h2c_tvalid = 1'b0;
    #1;
    checks++; if (h2c_drop_cnt !== 32'd2) begin failures++; $display("FAIL drop_cnt_multi got=%0d exp=2", h2c_drop_cnt); end
  endtask

  task automatic test_h2c_backpressure();
    logic [31:0] dat [6];
    logic        lst [6];
    logic        rdy [6];
    logic [3:0]  evld [6];
    dat  = '{32'h5A5A_0000, 32'h1234_5699, 32'h1234_5699, 32'h1234_5699, 32'h0000_0077, 32'h0000_0003};
    lst  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    evld = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1000};
    for (int i = 0; i < 6; i++) begin
      h2c_beat(dat[i], lst[i]);
      m_ch_tready = {3'b111, rdy[i]};
      #1;
      checks++; if (s_h2c_tready !== rdy[i] || m_ch_tvalid !== evld[i]) begin
        failures++; $display("FAIL bp_cycle%0d got rdy=%b vld=%h exp rdy=%b vld=%h", i, s_h2c_tready, m_ch_tvalid, rdy[i], evld[i]);
      end
      tick();
    end
    s_h2c_tvalid = 1'b0;
    m_ch_tready = 4'hF;
    #1;
    checks++; if (h2c_drop_cnt !== 32'd2) begin failures++; $display("FAIL bp_drop_cnt got=%0d exp=2", h2c_drop_cnt); end
  endtask

  task automatic test_c2h_rr();
    logic [3:0]  egnt [16];
    logic [15:0] edat [16];
    logic [NCH-1:0] hs;
    egnt = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1, 4'h0};
    edat = '{16'h0, 16'hC000, 16'hC001, 16'h0, 16'hC010, 16'hC011, 16'h0, 16'hC020, 16'hC021,
             16'h0, 16'hC030, 16'hC031, 16'h0, 16'hC002, 16'hC003, 16'h0};
    link_up = 1'b1;
    m_c2h_tready = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      src_pkts[c] = (c == 0) ? 2 : 1; src_len[c] = 2; src_beat[c] = 0; src_tot[c] = 0;
    end
    for (int i = 0; i < 16; i++) begin
      drive_sources();
      #1;
      checks++; if (c2h_grant !== egnt[i] || m_c2h_tvalid !== (egnt[i] != 4'h0)) begin
        failures++; $display("FAIL rr_grant cycle%0d got gnt=%h vld=%b exp gnt=%h", i, c2h_grant, m_c2h_tvalid, egnt[i]);
      end
      if (egnt[i] != 4'h0) begin
        checks++; if (m_c2h_tdata !== {16'h0, edat[i]} || m_c2h_tlast !== edat[i][0]) begin
          failures++; $display("FAIL rr_data cycle%0d got %h/%b exp %h/%b", i, m_c2h_tdata, m_c2h_tlast, edat[i], edat[i][0]);
        end
      end
      hs = s_ch_tvalid & s_ch_tready;
      tick();
      advance_sources(hs);
    end
  endtask

  task automatic test_c2h_linkup();
    logic        lu   [9];
    logic [3:0]  egnt [9];
    logic [15:0] edat [9];
    logic        elst [9];
    logic [NCH-1:0] hs;
    lu   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    egnt = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0};
    edat = '{16'h0, 16'hC010, 16'hC011, 16'hC012, 16'h0, 16'h0, 16'h0, 16'hC020, 16'h0};
    elst = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < NCH; c++) begin
      src_pkts[c] = (c == 1 || c == 2) ? 1 : 0; src_len[c] = (c == 1) ? 3 : 1;
      src_beat[c] = 0; src_tot[c] = 0;
    end
    for (int i = 0; i < 9; i++) begin
      link_up = lu[i];
      drive_sources();
      #1;
      checks++; if (c2h_grant !== egnt[i] || m_c2h_tvalid !== (egnt[i] != 4'h0)) begin
        failures++; $display("FAIL lu_grant cycle%0d got gnt=%h vld=%b exp gnt=%h", i, c2h_grant, m_c2h_tvalid, egnt[i]);
      end
      if (egnt[i] != 4'h0) begin
        checks++; if (m_c2h_tdata !== {16'h0, edat[i]} || m_c2h_tlast !== elst[i]) begin
          failures++; $display("FAIL lu_data cycle%0d got %h/%b exp %h/%b", i, m_c2h_tdata, m_c2h_tlast, edat[i], elst[i]);
        end
      end
      hs = s_ch_tvalid & s_ch_tready;
      tick();
      advance_sources(hs);
    end
  endtask

  task automatic test_reset_mid();
    link_up = 1'b1;
    m_ch_tready = 4'hF;
    for (int c = 0; c < NCH; c++) begin
      src_pkts[c] = (c == 2) ? 1 : 0; src_len[c] = 3; src_beat[c] = 0; src_tot[c] = 0;
    end
    h2c_beat(32'h0000_0001, 1'b0);
    drive_sources();
    #1;
    checks++; if (m_ch_tvalid !== 4'b0010) begin failures++; $display("FAIL rm_hdr got vld=%h exp=2", m_ch_tvalid); end
    tick();
    h2c_beat(32'h0000_0005, 1'b0);
    drive_sources();
    #1;
    checks++; if (c2h_grant !== 4'b0100 || m_c2h_tdata !== 32'h0000_C020) begin
      failures++; $display("FAIL rm_pre_grant got gnt=%h data=%h exp gnt=4 data=c020", c2h_grant, m_c2h_tdata);
    end
    axis_rst_n = 1'b0;
    #1;
    checks++; if (m_ch_tvalid !== 4'h0 || s_h2c_tready !== 1'b0) begin
      failures++; $display("FAIL rm_h2c_in_rst got vld=%h rdy=%b exp 0/0", m_ch_tvalid, s_h2c_tready);
    end
    checks++; if (m_c2h_tvalid !== 1'b0 || s_ch_tready !== 4'h0 || c2h_grant !== 4'h0) begin
      failures++; $display("FAIL rm_c2h_in_rst got vld=%b rdy=%h gnt=%h exp 0/0/0", m_c2h_tvalid, s_ch_tready, c2h_grant);
    end
    checks++; if (h2c_drop_cnt !== 32'd0) begin failures++; $display("FAIL rm_drop_cnt got=%0d exp=0", h2c_drop_cnt); end
    tick();
    #2;
    axis_rst_n = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      src_pkts[c] = (c == 0 || c == 3) ? 1 : 0; src_len[c] = 1; src_beat[c] = 0; src_tot[c] = 0;
    end
    h2c_beat(32'h0000_0003, 1'b1);
    drive_sources();
    #1;
    checks++; if (m_ch_tvalid !== 4'b1000 || s_h2c_tready !== 1'b1) begin
      failures++; $display("FAIL rm_h2c_header got vld=%h rdy=%b exp vld=8 rdy=1", m_ch_tvalid, s_h2c_tready);
    end
    tick();
    s_h2c_tvalid = 1'b0;
    drive_sources();
    #1;
    checks++; if (c2h_grant !== 4'b0001 || m_c2h_tdata !== 32'h0000_C000) begin
      failures++; $display("FAIL rm_first_prio got gnt=%h data=%h exp gnt=1 data=c000", c2h_grant, m_c2h_tdata);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_h2c_fwd();
    test_h2c_drop();
    test_h2c_backpressure();
    test_c2h_rr();
    test_c2h_linkup();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
